// File: rtl/ram_access_unit_pkg.sv
// Shared definitions for ram_access_unit: size encodings, byte-lane masks and FSM states.
package ram_access_unit_pkg;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;

    typedef enum logic [1:0] {
        StIdle,
        StBeat1,
        StFinish
    } state_e;

    // Right-justified byte-lane mask for an access size; encoding 3 behaves as a word.
    function automatic logic [3:0] size_mask(input logic [1:0] size);
        logic [3:0] mask;
        case (size)
            SZ_B:    mask = 4'b0001;
            SZ_H:    mask = 4'b0011;
            default: mask = 4'b1111;
        endcase
        return mask;
    endfunction

    // Lanes of the first (upper=0) or second (upper=1) word touched by a mask placed at offset k.
    function automatic logic [3:0] lane_mask(input logic [3:0] mask, input logic [1:0] k,
                                             input logic upper);
        logic [7:0] wide;
        wide = {4'b0000, mask} << k;
        return upper ? wide[7:4] : wide[3:0];
    endfunction

endpackage

// File: rtl/ram_access_unit_load_extend.sv
// Extracts the low 1/2/4 bytes of a load word and sign- or zero-extends them to 32 bits.
module ram_access_unit_load_extend
    import ram_access_unit_pkg::*;
(
    input  logic [31:0] raw,
    input  logic [1:0]  size,
    input  logic        sign_ext,
    output logic [31:0] data
);

    always_comb begin
        data = raw;
        case (size)
            SZ_B:    data = {{24{sign_ext & raw[7]}}, raw[7:0]};
            SZ_H:    data = {{16{sign_ext & raw[15]}}, raw[15:0]};
            default: data = raw;
        endcase
    end

endmodule

// File: rtl/ram_access_unit.sv
// Byte/half/word load-store initiator for one byte-enabled RAM port; accesses the RAM
// cannot do in one beat are split into two word-aligned beats.
module ram_access_unit
    import ram_access_unit_pkg::*;
#(
    parameter int unsigned SCALE = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_store,
    input  logic [1:0]       req_size,
    input  logic             req_signed,
    input  logic [SCALE-1:0] req_addr,
    input  logic [31:0]      req_wdata,
    output logic             resp_valid,
    output logic [31:0]      resp_rdata,
    output logic             ram_oe,
    output logic [SCALE-1:0] ram_addr,
    output logic [31:0]      ram_wdata,
    output logic [3:0]       ram_we,
    input  logic [31:0]      ram_rdata
);

    state_e           state_q, state_d;
    logic             store_q, sign_q, split_q;
    logic [1:0]       size_q, k_q;
    logic [31:0]      wdata_q, hold_q;
    logic [SCALE-1:0] next_addr_q;
    logic             resp_valid_q;
    logic [31:0]      resp_rdata_q;

    logic [1:0]       req_k;
    logic [3:0]       req_mask;
    logic             req_split;
    logic             accept;
    logic [SCALE-3:0] next_word;
    logic [4:0]       lo_shift;
    logic [5:0]       hi_shift;
    logic [31:0]      raw;
    logic [31:0]      ext;

    assign req_k     = req_addr[1:0];
    assign req_mask  = size_mask(req_size);
    assign req_split = (req_mask == 4'b1111 && req_k != 2'd0) ||
                       (req_mask == 4'b0011 && req_k == 2'd3);
    assign accept    = req_valid && req_ready;
    // Word index wraps naturally at the top of the RAM.
    assign next_word = req_addr[SCALE-1:2] + {{(SCALE-3){1'b0}}, 1'b1};

    assign lo_shift = {k_q, 3'b000};
    assign hi_shift = 6'd32 - {1'b0, lo_shift};
    assign raw      = split_q ? ((hold_q >> lo_shift) | (ram_rdata << hi_shift)) : ram_rdata;

    ram_access_unit_load_extend u_load_extend (
        .raw      (raw),
        .size     (size_q),
        .sign_ext (sign_q),
        .data     (ext)
    );

    always_comb begin
        state_d   = state_q;
        req_ready = 1'b0;
        ram_oe    = 1'b0;
        ram_addr  = '0;
        ram_we    = 4'b0000;
        ram_wdata = '0;
        case (state_q)
            StIdle: begin
                req_ready = !rst;
                if (req_valid && !rst) begin
                    ram_oe = 1'b1;
                    if (req_split) begin
                        state_d   = StBeat1;
                        ram_addr  = {req_addr[SCALE-1:2], 2'b00};
                        ram_we    = req_store ? lane_mask(req_mask, req_k, 1'b0) : 4'b0000;
                        ram_wdata = req_wdata << {req_k, 3'b000};
                    end else begin
                        // The RAM applies the in-word offset itself for single beats.
                        state_d   = StFinish;
                        ram_addr  = req_addr;
                        ram_we    = req_store ? req_mask : 4'b0000;
                        ram_wdata = req_wdata;
                    end
                end
            end
            StBeat1: begin
                ram_oe    = 1'b1;
                ram_addr  = next_addr_q;
                ram_we    = store_q ? lane_mask(size_mask(size_q), k_q, 1'b1) : 4'b0000;
                ram_wdata = wdata_q >> hi_shift;
                state_d   = StFinish;
            end
            StFinish: state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            store_q      <= 1'b0;
            sign_q       <= 1'b0;
            split_q      <= 1'b0;
            size_q       <= 2'd0;
            k_q          <= 2'd0;
            wdata_q      <= '0;
            next_addr_q  <= '0;
            hold_q       <= '0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
        end else begin
            state_q      <= state_d;
            resp_valid_q <= (state_q == StFinish);
            if (accept) begin
                store_q     <= req_store;
                sign_q      <= req_signed;
                split_q     <= req_split;
                size_q      <= req_size;
                k_q         <= req_k;
                wdata_q     <= req_wdata;
                next_addr_q <= {next_word, 2'b00};
            end
            // Beat0 read data arrives while beat1 is on the port.
            if (state_q == StBeat1) begin
                hold_q <= ram_rdata;
            end
            if (state_q == StFinish) begin
                resp_rdata_q <= store_q ? 32'd0 : ext;
            end
        end
    end

    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;

endmodule

// File: doc/ram_access_unit.md
# ram_access_unit

Initiator for one byte-enabled RAM port: accepts byte/half/word load-store requests from the core pipeline, drives the RAM's oe/addr/wdata/we/rdata port, and returns sign- or zero-extended load data. Natively legal accesses pass straight through. Accesses the RAM cannot do in one beat are split into two word-aligned beats:
- word at offset 1..3;
- half at offset 3.

One instance sits in front of each RAM port (instruction fetch, load/store).

## Interface
- SCALE, 10, RAM size is 2**SCALE bytes; address width; must be >=3
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- req_valid  in  1  request present
- req_ready  out  1  request accepted when req_valid & req_ready
- req_store  in  1  1 = store, 0 = load
- req_size  in  2  0 byte, 1 half, 2 word, 3 treated as word
- req_signed  in  1  sign-extend byte/half loads; ignored otherwise
- req_addr  in  SCALE  byte address
- req_wdata  in  32  store data, right-justified
- resp_valid  out  1  one-cycle pulse per completed request (loads and stores)
- resp_rdata  out  32  extended load data; 0 for stores
- ram_oe  out  1  RAM port enable
- ram_addr  out  SCALE  RAM byte address
- ram_wdata  out  32  RAM write data
- ram_we  out  4  RAM byte write enables (0 = read)
- ram_rdata  in  32  RAM read data, valid the cycle after ram_oe, right-shifted by the RAM by addr[1:0]

## Operation
- k = req_addr[1:0]; n = size in bytes (1/2/4).
- split = (n==4 && k!=0) || (n==2 && k==3).
- States: IDLE, BEAT1, FINISH.
- IDLE:
  - req_ready=1.
  - On accept, beat0 is driven combinationally in the same cycle with ram_oe=1.
  - Captured into registers: store, size, signed, k, wdata, next-word address.
- Non-split beat0:
  - ram_addr=req_addr.
  - ram_we = store ? (0001/0011/1111 for n=1/2/4) : 0000.
  - ram_wdata=req_wdata; the RAM applies the offset shift itself.
  - Next state FINISH.
- Split beat0:
  - ram_addr={req_addr[SCALE-1:2],2'b00}.
  - ram_we = store ? (mask<<k)[3:0] : 0, where mask = 1111 for word, 0011 for half.
  - ram_wdata = req_wdata<<(8k).
  - Next state BEAT1.
- BEAT1:
  - ram_oe=1.
  - ram_addr = {req_addr[SCALE-1:2]+1, 2'b00}; the word index wraps modulo 2**(SCALE-2).
  - ram_we = store ? (mask<<k)[7:4] : 0.
  - ram_wdata = wdata>>(8(4-k)).
  - Latch ram_rdata (beat0 word) into hold register.
  - Next state FINISH.
- FINISH:
  - ram_oe=0, req_ready=0.
  - Non-split raw = ram_rdata.
  - Split raw = (hold>>(8k)) | (ram_rdata<<(8(4-k))).
  - Extract low n bytes; extend per req_signed; register into resp_rdata (0 if store); set resp_valid for one cycle.
  - Next state IDLE.
- Byte order is little-endian throughout.
- Never emit an enable pattern the RAM rejects: 0111, half at offset 3, or word at offset != 0 in a single beat.
- In IDLE with req_valid=0: ram_oe=0, ram_we=0.

## Timing
- Reset (async assert, sync deassert assumed upstream): state=IDLE, resp_valid=0, resp_rdata=0, hold=0. While rst=1, req_ready=0 and ram_oe=0.
- Non-split: accept at T; ram_oe at T; resp_valid at T+2.
- Split: beats at T and T+1; resp_valid at T+3.
- Next accept is possible in the cycle resp_valid is high, because IDLE is re-entered.
- Throughput: 1 request per 2 cycles (non-split), per 3 cycles (split).
- Request inputs are sampled only at accept; they may change afterwards.
- Reset mid-split store: beat0 bytes may already be written; the request is dropped and no response is produced.
- resp_rdata holds its value between pulses.

## Structure
- Shared package: SZ_B/SZ_H/SZ_W encodings, size-to-mask function, state encoding.
- One combinational sub-module, load_extend:
  - inputs: raw 32b, size, signed;
  - output: 32b extended data.

## Test plan
- Aligned word store 0xDEADBEEF at 0x10, then load word 0x10 -> single beats, we=1111, resp_rdata=0xDEADBEEF at T+2.
- Byte load at 0x13 with signed=1 after the above -> 0xFFFFFFDE; with signed=0 -> 0x000000DE.
- Word store 0x11223344 at 0x21 -> beat0 addr 0x20 we=1110 wdata 0x22334400; beat1 addr 0x24 we=0001 wdata 0x00000011. Word load at 0x21 -> 0x11223344 at T+3.
- Half store 0xA5C3 at 0x0B, then signed half load at 0x0B -> beats we=1000 / 0001; load returns 0xFFFFA5C3.
- Word store at address 2**SCALE-2 (SCALE=10: 0x3FE) -> beat1 address wraps to 0x000 with we=0011.
- Assert rst during BEAT1 of a split load -> no resp_valid, req_ready=0 during reset, then 1 after release; the next aligned load completes normally.
